// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Imported by fetch_fifo and fetch_stage.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch entries with push/pop/flush.
// Flush takes priority over a simultaneous push or pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  fetch_entry_t i_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head,
    output logic [CW-1:0] o_count,
    output logic         o_full,
    output logic         o_empty
);

    fetch_entry_t r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, credit-limited imem requests, prefetch FIFO, IF/ID reg.
// Optional FETCH_PERF_EN adds perf_fetched / perf_discarded counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_discarded
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_discard;
    logic [XLEN-1:0] r_pcq [FIFO_DEPTH];
    logic [AW-1:0]   r_pcq_wr;
    logic [AW-1:0]   r_pcq_rd;
    logic            r_id_valid;
    logic [XLEN-1:0] r_id_instr;
    logic [XLEN-1:0] r_id_pc;
    logic [XLEN-1:0] r_id_pc_plus4;

    logic          w_credit_ok;
    logic          w_issue;
    logic          w_rsp_keep;
    logic          w_load;
    logic          w_pop;
    fetch_entry_t  w_push_data;
    fetch_entry_t  w_head;
    logic [CW-1:0] w_fifo_count;
    logic          w_fifo_full;
    logic          w_fifo_empty;

    // Requests in flight plus buffered entries never exceed the FIFO size.
    assign w_credit_ok = ({1'b0, r_inflight} + {1'b0, w_fifo_count}) < DEPTH_C;
    assign imem_req_valid = !rst && !redirect_valid && !w_fifo_full && w_credit_ok;
    assign imem_req_addr  = r_pc;
    assign w_issue = imem_req_valid && imem_req_ready;

    assign w_rsp_keep  = imem_rsp_valid && (r_discard == '0);
    assign w_push_data = '{instr: imem_rsp_data, pc: r_pcq[r_pcq_rd]};

    assign w_load = !redirect_valid && (!stall || !r_id_valid);
    assign w_pop  = w_load && !w_fifo_empty;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rsp_keep),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_pcq[r_pcq_wr] <= r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
            r_pcq_wr   <= '0;
            r_pcq_rd   <= '0;
        end else begin
            r_inflight <= r_inflight + CW'(w_issue) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                r_pc      <= redirect_pc & ~32'h3;
                r_discard <= r_inflight - CW'(imem_rsp_valid);
                r_pcq_wr  <= '0;
                r_pcq_rd  <= '0;
            end else begin
                if (w_issue) begin
                    r_pc     <= r_pc + 32'd4;
                    r_pcq_wr <= r_pcq_wr + AW'(1);
                end
                if (imem_rsp_valid) begin
                    if (r_discard != '0) begin
                        r_discard <= r_discard - CW'(1);
                    end else begin
                        r_pcq_rd <= r_pcq_rd + AW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_valid    <= 1'b0;
            r_id_instr    <= NOP_INSTR;
            r_id_pc       <= '0;
            r_id_pc_plus4 <= '0;
        end else if (redirect_valid) begin
            r_id_valid <= 1'b0;
            r_id_instr <= NOP_INSTR;
        end else if (w_load) begin
            if (!w_fifo_empty) begin
                r_id_valid    <= 1'b1;
                r_id_instr    <= w_head.instr;
                r_id_pc       <= w_head.pc;
                r_id_pc_plus4 <= w_head.pc + 32'd4;
            end else begin
                r_id_valid <= 1'b0;
                r_id_instr <= NOP_INSTR;
            end
        end
    end

    assign id_valid    = r_id_valid;
    assign id_instr    = r_id_instr;
    assign id_pc       = r_id_pc;
    assign id_pc_plus4 = r_id_pc_plus4;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_discarded;
    logic        w_dropped;

    assign w_dropped = imem_rsp_valid && (redirect_valid || r_discard != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched   <= '0;
            r_perf_discarded <= '0;
        end else begin
            if (w_pop) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_dropped) begin
                r_perf_discarded <= r_perf_discarded + 32'd1;
            end
        end
    end

    assign perf_fetched   = r_perf_fetched;
    assign perf_discarded = r_perf_discarded;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: phase table plus memory model and in-order scoreboard.
// Exercises perf counters too when built with FETCH_PERF_EN.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_discarded;
`endif

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC   (RPC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_discarded (perf_discarded)
`endif
    );

    typedef struct {
        bit          rst;
        bit          ready;
        bit          stall;
        bit          redir;
        logic [31:0] rpc;
        int          n;
        int          lat;
        bit          ck_idv;
        bit          idv;
        bit          ck_addr;
        logic [31:0] addr;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] expq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          loads = 0;
    logic [31:0] exp_pc = RPC;
    logic [31:0] last_pc = '0;
    logic [31:0] prev_hs = '0;
    bit          wrap_seen = 1'b0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input bit rst_i, input bit ready_i, input bit stall_i,
                        input bit redir_i, input logic [31:0] rpc_i);
        bit          hs;
        bit          rsp;
        logic [31:0] hs_addr;
        logic [31:0] exp_front;
        bit          pv_idv;
        logic [31:0] pv_instr;
        logic [31:0] pv_pc;
        logic [31:0] pv_pc4;
        @(negedge clk);
        rst            = rst_i;
        imem_req_ready = ready_i;
        stall          = stall_i;
        redirect_valid = redir_i;
        redirect_pc    = rpc_i;
        rsp = (pend.size() > 0) && (pend[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? memf(pend[0].addr) : 32'h0;
        #1;
        hs      = imem_req_valid && imem_req_ready;
        hs_addr = imem_req_addr;
        if (rst_i || redir_i) chk("req_valid_blocked", 32'(imem_req_valid), 0);
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_pc);
        chk("outstanding_le_2", 32'(pend.size() <= 2), 1);
        pv_idv   = id_valid;
        pv_instr = id_instr;
        pv_pc    = id_pc;
        pv_pc4   = id_pc_plus4;
        @(posedge clk);
        #1;
        cyc++;
        if (rsp) void'(pend.pop_front());
        if (rst_i) begin
            pend.delete();
            expq.delete();
            exp_pc = RPC;
            chk("rst_id_valid", 32'(id_valid), 0);
            chk("rst_id_instr", id_instr, NOP_INSTR);
            chk("rst_id_pc", id_pc, 0);
            chk("rst_id_pc4", id_pc_plus4, 0);
        end else begin
            if (redir_i) begin
                chk("redir_id_valid", 32'(id_valid), 0);
                chk("redir_id_instr", id_instr, NOP_INSTR);
                expq.delete();
                exp_pc = rpc_i & ~32'h3;
            end else if (stall_i && pv_idv) begin
                chk("stall_valid", 32'(id_valid), 1);
                chk("stall_instr", id_instr, pv_instr);
                chk("stall_pc", id_pc, pv_pc);
                chk("stall_pc4", id_pc_plus4, pv_pc4);
            end else if (id_valid) begin
                loads++;
                last_pc = id_pc;
                if (expq.size() == 0) begin
                    chk("sb_unexpected_load", id_pc, 32'hFFFF_FFFF);
                end else begin
                    exp_front = expq.pop_front();
                    chk("id_pc", id_pc, exp_front);
                    chk("id_instr", id_instr, memf(exp_front));
                    chk("id_pc_plus4", id_pc_plus4, exp_front + 32'd4);
                end
            end else begin
                chk("bubble_nop", id_instr, NOP_INSTR);
            end
            if (hs) begin
                pend.push_back('{addr: hs_addr, due: cyc + lat - 1});
                expq.push_back(hs_addr);
                exp_pc = exp_pc + 32'd4;
                if (hs_addr == 32'h0 && prev_hs == 32'hFFFF_FFFC) wrap_seen = 1'b1;
                prev_hs = hs_addr;
            end
        end
    endtask

    vec_t tbl[$];

    initial begin
        int          base;
        logic [31:0] pdisc;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = 1'b0;
        pdisc          = '0;

        // rst ready stall redir rpc n lat ck_idv idv ck_addr addr
        tbl.push_back('{1, 1, 0, 0, 32'h0, 2, 1, 1, 0, 0, 32'h0});
        tbl.push_back('{0, 1, 0, 0, 32'h0, 1, 1, 0, 0, 1, 32'h104});
        tbl.push_back('{0, 0, 0, 0, 32'h0, 3, 1, 0, 0, 1, 32'h104});
        tbl.push_back('{0, 1, 0, 0, 32'h0, 12, 1, 0, 0, 0, 32'h0});
        tbl.push_back('{0, 1, 1, 0, 32'h0, 5, 1, 1, 1, 0, 32'h0});
        tbl.push_back('{0, 1, 0, 0, 32'h0, 6, 1, 0, 0, 0, 32'h0});
        tbl.push_back('{0, 1, 1, 1, 32'h3001, 1, 1, 1, 0, 1, 32'h3000});
        tbl.push_back('{0, 1, 0, 0, 32'h0, 8, 3, 0, 0, 0, 32'h0});
        tbl.push_back('{0, 1, 0, 1, 32'hFFFF_FFF8, 1, 1, 1, 0, 1, 32'hFFFF_FFF8});
        tbl.push_back('{0, 1, 0, 0, 32'h0, 12, 1, 0, 0, 0, 32'h0});

        for (int i = 0; i < tbl.size(); i++) begin
            lat = tbl[i].lat;
            for (int k = 0; k < tbl[i].n; k++) begin
                tick(tbl[i].rst, tbl[i].ready, tbl[i].stall, tbl[i].redir, tbl[i].rpc);
            end
            if (tbl[i].ck_idv) chk($sformatf("row%0d_id_valid", i), 32'(id_valid), 32'(tbl[i].idv));
            if (tbl[i].ck_addr) chk($sformatf("row%0d_req_addr", i), imem_req_addr, tbl[i].addr);
        end
        chk("pc_wrap_seen", 32'(wrap_seen), 1);

        // redirect with two requests outstanding
        lat = 4;
        for (int i = 0; i < 30 && pend.size() != 2; i++) tick(0, 1, 0, 0, 0);
        chk("two_inflight", 32'(pend.size()), 2);
`ifdef FETCH_PERF_EN
        pdisc = perf_discarded;
`endif
        tick(0, 1, 0, 1, 32'h2002);
        chk("redir_req_addr", imem_req_addr, 32'h2000);
        base = loads;
        for (int i = 0; i < 30 && loads == base; i++) tick(0, 1, 0, 0, 0);
        chk("redir_load_seen", 32'(loads > base), 1);
        chk("redir_first_pc", last_pc, 32'h2000);
`ifdef FETCH_PERF_EN
        chk("perf_discarded", perf_discarded - pdisc, 2);
        chk("perf_fetched_nz", 32'(perf_fetched != 0), 1);
`endif
        for (int i = 0; i < 8; i++) tick(0, 1, 0, 0, 0);

        // reset with a response outstanding
        lat = 2;
        for (int i = 0; i < 20 && pend.size() == 0; i++) tick(0, 1, 0, 0, 0);
        chk("pre_rst_inflight", 32'(pend.size() > 0), 1);
        tick(1, 1, 0, 0, 0);
        lat = 1;
        base = loads;
        for (int i = 0; i < 20 && loads == base; i++) tick(0, 1, 0, 0, 0);
        chk("rst_load_seen", 32'(loads > base), 1);
        chk("rst_first_pc", last_pc, RPC);
`ifdef FETCH_PERF_EN
        chk("perf_disc_after_rst", perf_discarded, 0);
`endif
        for (int i = 0; i < 6; i++) tick(0, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
